rename_regfile: RTL and testbench
=================================

# rename_regfile

Parametrised architectural register file with per-register rename tags for the out-of-order core, sitting between issue/decode and ROB commit. It supports NRD combinational read ports with same-cycle commit bypass, NISS issue (tag-allocate) ports and NCOM commit ports per cycle. An optional debug scan engine streams the whole file out over a valid/ready handshake.

## Interface
- XLEN, 32, data width
- NREG, 32, architectural register count; register 0 hard-wired to zero; RW = $clog2(NREG)
- TW, 5, rob tag width including wrap bit; tag 0 reserved as "no pending producer", never allocated by ROB
- NRD, 4, read ports; NISS, 2, issue ports; NCOM, 2, commit ports; higher index = younger in program order
- clk in 1: sole clock
- rst in 1: asynchronous, active-high reset
- rdy in 1: global stall; low freezes all state
- clr in 1: mispredict flush
- iss_en in NISS; iss_rd in NISS*RW; iss_tag in NISS*TW: allocate tag to rd
- com_en in NCOM; com_rd in NCOM*RW; com_tag in NCOM*TW; com_val in NCOM*XLEN: commit results
- rd_addr in NRD*RW; rd_val out NRD*XLEN; rd_tag out NRD*TW: operand lookup, combinational
- scan_req in 1; scan_valid out 1; scan_ready in 1; scan_idx out RW; scan_val out XLEN; scan_tag out TW; scan_done out 1 (REGFILE_SCAN_EN only)

## Operation
- State: val[NREG], tag[NREG]. Reset: all zero; scan FSM IDLE; scan outputs zero.
- Register 0: writes/allocations ignored; reads return val 0, tag 0.
- Read port k: if any enabled commit j has com_rd==rd_addr[k]!=0 and com_tag==tag[rd_addr[k]], return com_val[j], tag 0; else val/tag from arrays. Read sees pre-issue state; intra-bundle dependencies resolved by decode.
- Commit j (enabled, rd!=0): val[rd] <= com_val; tag[rd] <= 0 only if com_tag==tag[rd]. Several commits to same rd: youngest value wins.
- Issue i (enabled, rd!=0): tag[rd] <= iss_tag. Same-rd issues: youngest wins. Issue overrides same-cycle commit tag clear.
- clr (rdy-qualified like all updates): commit value writes still performed; all tags cleared; issues ignored.
- rdy low: no array or FSM update; reads remain live.

## Timing
- Read: zero latency; array updates visible the cycle after the posedge.
- Scan FSM: IDLE, SCAN. IDLE+scan_req -> SCAN, idx 0. In SCAN scan_valid=1 showing val[idx], tag[idx] (registered, no bypass); on scan_valid&&scan_ready idx++; payload stable while !scan_ready. Accept at idx NREG-1 -> IDLE, scan_done one-cycle pulse. scan_req in SCAN ignored. clr does not abort scan. Async rst mid-scan -> IDLE, scan_valid 0 immediately.

## Configuration
- REGFILE_SCAN_EN defined: scan FSM and scan ports present.
- Undefined: scan ports absent; no FSM logic; core behaviour identical.

## Structure
- Shared package/definition header: XLEN, TW, REG width defaults, TAG_NONE=0, scan state encodings.
- One sub-module: rename_regfile_scan (FSM, index counter, handshake), instantiated under REGFILE_SCAN_EN.

## Test plan
- Reset, issue x5 tag 3, read x5 -> tag 3; commit x5 tag 3 val 0xDEAD -> same-cycle read val 0xDEAD tag 0; next cycle tag[5]=0.
- x5 tag 3, issue x5 tag 7, commit tag 3 val 0x11 -> val[5]=0x11, tag stays 7, read returns tag 7.
- Same cycle: commit x6 clears its tag and issue x6 tag 9 -> tag[6]=9; two issues to x6 tags 9,10 -> 10.
- clr with commit x7 val 0x55 and issue x8 tag 4 -> val[7]=0x55, all tags 0, tag[8]=0.
- Writes/issues to x0 -> read x0 val 0 tag 0; rdy low with commit pending -> no state change.
- Scan with scan_ready toggling every other cycle -> 32 beats idx 0..31, payload held while stalled, scan_done once after idx 31; rst mid-scan -> scan_valid 0.

Source files
------------

// File: rtl/rename_regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rename_regfile_pkg
// Purpose  : Shared widths, the "no pending producer" tag value and the
//            debug scan FSM state encodings for the rename register file.
// Revision : 1.0 - initial release
// ============================================================================
package rename_regfile_pkg;

  localparam int DEF_XLEN = 32;
  localparam int DEF_NREG = 32;
  localparam int DEF_TW   = 5;

  // Tag value meaning "architectural value is current"; the ROB never hands it out.
  localparam int TAG_NONE = 0;

  // Debug scan FSM states
  localparam logic [0:0] SCAN_IDLE = 1'b0;
  localparam logic [0:0] SCAN_RUN  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/rename_regfile_scan.sv
`default_nettype none
// ============================================================================
// Module   : rename_regfile_scan
// Purpose  : Debug scan engine. Walks register index 0..NREG-1 and presents
//            each value/tag as one valid/ready beat. The payload is captured
//            into registers so it stays put while the consumer stalls.
// Revision : 1.0 - initial release
// ============================================================================
module rename_regfile_scan
  import rename_regfile_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int NREG = DEF_NREG,
  parameter int TW   = DEF_TW,
  parameter int RW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_rdy,
  input  logic            i_req,
  input  logic            i_ready,
  input  logic [XLEN-1:0] i_fetch_val,
  input  logic [TW-1:0]   i_fetch_tag,
  output logic [RW-1:0]   o_fetch_idx,
  output logic            o_valid,
  output logic [RW-1:0]   o_idx,
  output logic [XLEN-1:0] o_val,
  output logic [TW-1:0]   o_tag,
  output logic            o_done
);

  localparam logic [RW-1:0] LAST_IDX = RW'(NREG - 1);

  logic [0:0]      r_state;
  logic [RW-1:0]   r_idx;
  logic [XLEN-1:0] r_val;
  logic [TW-1:0]   r_tag;
  logic            r_done;

  // Index whose contents get loaded on the next beat advance (0 when starting).
  always_comb o_fetch_idx = (r_state == SCAN_RUN) ? r_idx + 1'b1 : '0;

  // Scan FSM: start on request, advance on each accepted beat, pulse done at the end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= SCAN_IDLE;
      r_idx   <= '0;
      r_val   <= '0;
      r_tag   <= '0;
      r_done  <= 1'b0;
    end else if (i_rdy) begin
      r_done <= 1'b0;
      case (r_state)
        SCAN_IDLE: begin
          if (i_req) begin
            r_state <= SCAN_RUN;
            r_idx   <= '0;
            r_val   <= i_fetch_val;
            r_tag   <= i_fetch_tag;
          end
        end
        SCAN_RUN: begin
          if (i_ready) begin
            if (r_idx == LAST_IDX) begin
              r_state <= SCAN_IDLE;
              r_idx   <= '0;
              r_val   <= '0;
              r_tag   <= '0;
              r_done  <= 1'b1;
            end else begin
              r_idx <= r_idx + 1'b1;
              r_val <= i_fetch_val;
              r_tag <= i_fetch_tag;
            end
          end
        end
        default: r_state <= SCAN_IDLE;
      endcase
    end
  end

  assign o_valid = (r_state == SCAN_RUN);
  assign o_idx   = r_idx;
  assign o_val   = r_val;
  assign o_tag   = r_tag;
  assign o_done  = r_done;

endmodule
`default_nettype wire

// File: rtl/rename_regfile.sv
`default_nettype none
// ============================================================================
// Module   : rename_regfile
// Purpose  : Architectural register file with per-register rename tags.
//            NRD combinational read ports with commit bypass, NISS tag
//            allocate ports, NCOM commit ports. Higher port index = younger.
//            Define REGFILE_SCAN_EN to add the debug scan engine and ports.
// Revision : 1.0 - initial release
// ============================================================================
module rename_regfile
  import rename_regfile_pkg::*;
#(
  parameter  int XLEN = DEF_XLEN,
  parameter  int NREG = DEF_NREG,
  parameter  int TW   = DEF_TW,
  parameter  int NRD  = 4,
  parameter  int NISS = 2,
  parameter  int NCOM = 2,
  localparam int RW   = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef REGFILE_SCAN_EN
  input  logic                 i_scan_req,
  output logic                 o_scan_valid,
  input  logic                 i_scan_ready,
  output logic [RW-1:0]        o_scan_idx,
  output logic [XLEN-1:0]      o_scan_val,
  output logic [TW-1:0]        o_scan_tag,
  output logic                 o_scan_done,
`endif
  input  logic                 i_rdy,
  input  logic                 i_clr,
  input  logic [NISS-1:0]      i_iss_en,
  input  logic [NISS*RW-1:0]   i_iss_rd,
  input  logic [NISS*TW-1:0]   i_iss_tag,
  input  logic [NCOM-1:0]      i_com_en,
  input  logic [NCOM*RW-1:0]   i_com_rd,
  input  logic [NCOM*TW-1:0]   i_com_tag,
  input  logic [NCOM*XLEN-1:0] i_com_val,
  input  logic [NRD*RW-1:0]    i_rd_addr,
  output logic [NRD*XLEN-1:0]  o_rd_val,
  output logic [NRD*TW-1:0]    o_rd_tag
);

  logic [XLEN-1:0] r_val [NREG];
  logic [TW-1:0]   r_tag [NREG];
  logic [XLEN-1:0] w_val_nxt [NREG];
  logic [TW-1:0]   w_tag_nxt [NREG];

  logic [RW-1:0]   w_iss_rd  [NISS];
  logic [TW-1:0]   w_iss_tag [NISS];
  logic [RW-1:0]   w_com_rd  [NCOM];
  logic [TW-1:0]   w_com_tag [NCOM];
  logic [XLEN-1:0] w_com_val [NCOM];

  for (genvar i = 0; i < NISS; i++) begin : g_iss_unpack
    assign w_iss_rd[i]  = i_iss_rd[i*RW +: RW];
    assign w_iss_tag[i] = i_iss_tag[i*TW +: TW];
  end

  for (genvar j = 0; j < NCOM; j++) begin : g_com_unpack
    assign w_com_rd[j]  = i_com_rd[j*RW +: RW];
    assign w_com_tag[j] = i_com_tag[j*TW +: TW];
    assign w_com_val[j] = i_com_val[j*XLEN +: XLEN];
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [RW-1:0]   w_addr;
    logic [XLEN-1:0] w_v;
    logic [TW-1:0]   w_t;
    assign w_addr = i_rd_addr[k*RW +: RW];
    // Operand lookup: a commit retiring the current producer is forwarded; x0 reads zero.
    always_comb begin
      w_v = r_val[w_addr];
      w_t = r_tag[w_addr];
      for (int j = 0; j < NCOM; j++) begin
        if (i_com_en[j] && (w_com_rd[j] == w_addr) && (w_com_tag[j] == r_tag[w_addr])) begin
          w_v = w_com_val[j];
          w_t = TW'(TAG_NONE);
        end
      end
      if (w_addr == '0) begin
        w_v = '0;
        w_t = TW'(TAG_NONE);
      end
    end
    assign o_rd_val[k*XLEN +: XLEN] = w_v;
    assign o_rd_tag[k*TW +: TW]     = w_t;
  end

  // Next array state: commits (oldest first), then flush or issue allocation on top.
  always_comb begin
    w_val_nxt = r_val;
    w_tag_nxt = r_tag;
    for (int j = 0; j < NCOM; j++) begin
      if (i_com_en[j] && (w_com_rd[j] != '0)) begin
        w_val_nxt[w_com_rd[j]] = w_com_val[j];
        if (w_com_tag[j] == r_tag[w_com_rd[j]])
          w_tag_nxt[w_com_rd[j]] = TW'(TAG_NONE);
      end
    end
    if (i_clr) begin
      for (int r = 0; r < NREG; r++) w_tag_nxt[r] = TW'(TAG_NONE);
    end else begin
      for (int i = 0; i < NISS; i++) begin
        if (i_iss_en[i] && (w_iss_rd[i] != '0))
          w_tag_nxt[w_iss_rd[i]] = w_iss_tag[i];
      end
    end
  end

  // Array update, frozen while the pipeline is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        r_val[r] <= '0;
        r_tag[r] <= '0;
      end
    end else if (i_rdy) begin
      r_val <= w_val_nxt;
      r_tag <= w_tag_nxt;
    end
  end

`ifdef REGFILE_SCAN_EN
  logic [RW-1:0] w_fetch_idx;

  rename_regfile_scan #(
    .XLEN (XLEN),
    .NREG (NREG),
    .TW   (TW),
    .RW   (RW)
  ) u_scan (
    .clk         (clk),
    .rst         (rst),
    .i_rdy       (i_rdy),
    .i_req       (i_scan_req),
    .i_ready     (i_scan_ready),
    .i_fetch_val (r_val[w_fetch_idx]),
    .i_fetch_tag (r_tag[w_fetch_idx]),
    .o_fetch_idx (w_fetch_idx),
    .o_valid     (o_scan_valid),
    .o_idx       (o_scan_idx),
    .o_val       (o_scan_val),
    .o_tag       (o_scan_tag),
    .o_done      (o_scan_done)
  );
`endif

endmodule
`default_nettype wire

// File: tb/tb_rename_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_rename_regfile
// Purpose  : Directed self-checking bench for rename_regfile with an
//            expected-value queue. Scan checks compile in with REGFILE_SCAN_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rename_regfile;

  localparam int XLEN = 32;
  localparam int RW   = 5;
  localparam int TW   = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         rdy;
  logic         clr;
  logic [1:0]   iss_en;
  logic [9:0]   iss_rd;
  logic [9:0]   iss_tag;
  logic [1:0]   com_en;
  logic [9:0]   com_rd;
  logic [9:0]   com_tag;
  logic [63:0]  com_val;
  logic [19:0]  rd_addr;
  logic [127:0] rd_val;
  logic [19:0]  rd_tag;
`ifdef REGFILE_SCAN_EN
  logic         scan_req;
  logic         scan_valid;
  logic         scan_ready;
  logic [4:0]   scan_idx;
  logic [31:0]  scan_val;
  logic [4:0]   scan_tag;
  logic         scan_done;
`endif

  always #5 clk = ~clk;

  rename_regfile dut (
    .clk          (clk),
    .rst          (rst),
`ifdef REGFILE_SCAN_EN
    .i_scan_req   (scan_req),
    .o_scan_valid (scan_valid),
    .i_scan_ready (scan_ready),
    .o_scan_idx   (scan_idx),
    .o_scan_val   (scan_val),
    .o_scan_tag   (scan_tag),
    .o_scan_done  (scan_done),
`endif
    .i_rdy        (rdy),
    .i_clr        (clr),
    .i_iss_en     (iss_en),
    .i_iss_rd     (iss_rd),
    .i_iss_tag    (iss_tag),
    .i_com_en     (com_en),
    .i_com_rd     (com_rd),
    .i_com_tag    (com_tag),
    .i_com_val    (com_val),
    .i_rd_addr    (rd_addr),
    .o_rd_val     (rd_val),
    .o_rd_tag     (rd_tag)
  );

  typedef struct {
    string       nm;
    logic [63:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [63:0] pk(input logic [4:0] t, input logic [31:0] v);
    return {27'b0, t, v};
  endfunction

  task automatic push(input string nm, input logic [4:0] t, input logic [31:0] v);
    sb.push_back('{nm, pk(t, v)});
  endtask

  task automatic chk(input logic [63:0] obs);
    exp_t e;
    e = sb.pop_front();
    n_tests++;
    assert (obs === e.exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", e.nm, obs, e.exp);
    end
  endtask

  task automatic chk_rd(input int k);
    chk(pk(rd_tag[k*TW +: TW], rd_val[k*XLEN +: XLEN]));
  endtask

  task automatic idle();
    clr = 1'b0; iss_en = '0; com_en = '0;
  endtask

  task automatic iss(input int p, input int rd, input int tag);
    iss_en[p] = 1'b1;
    iss_rd[p*RW +: RW]  = RW'(rd);
    iss_tag[p*TW +: TW] = TW'(tag);
  endtask

  task automatic com(input int p, input int rd, input int tag, input logic [31:0] v);
    com_en[p] = 1'b1;
    com_rd[p*RW +: RW]     = RW'(rd);
    com_tag[p*TW +: TW]    = TW'(tag);
    com_val[p*XLEN +: XLEN] = v;
  endtask

  task automatic rda(input int k, input int a);
    rd_addr[k*RW +: RW] = RW'(a);
  endtask

`ifdef REGFILE_SCAN_EN
  logic [31:0] m_val [32];
  logic [4:0]  m_tag [32];
`endif

  initial begin
    rst = 1'b1; rdy = 1'b1; clr = 1'b0;
    iss_en = '0; iss_rd = '0; iss_tag = '0;
    com_en = '0; com_rd = '0; com_tag = '0; com_val = '0;
    rd_addr = '0;
`ifdef REGFILE_SCAN_EN
    scan_req = 1'b0; scan_ready = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rda(0, 5);
    push("reset_x5", 0, 0); #1 chk_rd(0);
`ifdef REGFILE_SCAN_EN
    push("reset_scan_valid", 0, 0); chk({63'b0, scan_valid});
`endif
    @(negedge clk); rst = 1'b0;

    // Issue x5 tag 3; the read in the issue cycle still sees the old state
    iss(0, 5, 3);
    push("pre_issue_x5", 0, 0); #1 chk_rd(0);
    @(negedge clk); idle();
    push("issued_x5", 3, 0); #1 chk_rd(0);

    // Commit retiring the pending producer: same-cycle bypass then settled value
    com(0, 5, 3, 32'hDEAD);
    push("bypass_x5", 0, 32'hDEAD); #1 chk_rd(0);
    @(negedge clk); idle();
    push("committed_x5", 0, 32'hDEAD); #1 chk_rd(0);

    // Stale commit: value lands, newer tag survives
    iss(0, 5, 3);
    @(negedge clk); idle(); iss(0, 5, 7);
    @(negedge clk); idle(); com(0, 5, 3, 32'h11);
    push("stale_commit_read", 7, 32'hDEAD); #1 chk_rd(0);
    @(negedge clk); idle();
    push("stale_commit_x5", 7, 32'h11); #1 chk_rd(0);

    // Issue overrides same-cycle commit tag clear; youngest of two issues wins
    rda(1, 6);
    iss(0, 6, 5);
    @(negedge clk); idle(); com(1, 6, 5, 32'h66); iss(0, 6, 9);
    @(negedge clk); idle();
    push("issue_over_clear_x6", 9, 32'h66); #1 chk_rd(1);
    iss(0, 6, 9); iss(1, 6, 10);
    @(negedge clk); idle();
    push("two_issues_x6", 10, 32'h66); #1 chk_rd(1);

    // Two commits to x9: older retires the producer, younger value is kept
    rda(2, 9);
    iss(0, 9, 6);
    @(negedge clk); idle(); com(0, 9, 6, 32'hA); com(1, 9, 2, 32'hB);
    push("bypass_match_x9", 0, 32'hA); #1 chk_rd(2);
    @(negedge clk); idle();
    push("youngest_val_x9", 0, 32'hB); #1 chk_rd(2);

    // Flush: commit value kept, issue dropped, every tag cleared
    rda(0, 7); rda(1, 8); rda(2, 5); rda(3, 6);
    clr = 1'b1; com(0, 7, 1, 32'h55); iss(0, 8, 4);
    @(negedge clk); idle();
    push("clr_x7", 0, 32'h55); push("clr_x8", 0, 0);
    push("clr_x5", 0, 32'h11); push("clr_x6", 0, 32'h66);
    #1 chk_rd(0); chk_rd(1); chk_rd(2); chk_rd(3);

    // x0 ignores writes and allocations
    rda(0, 0);
    iss(0, 0, 3); com(0, 0, 0, 32'hFFFF);
    push("x0_same_cycle", 0, 0); #1 chk_rd(0);
    @(negedge clk); idle();
    push("x0_after", 0, 0); #1 chk_rd(0);

    // Stall: nothing updates while rdy is low
    rda(0, 7); rda(1, 5);
    rdy = 1'b0; com(0, 7, 0, 32'h77); iss(0, 5, 13);
    @(negedge clk); idle(); rdy = 1'b1;
    push("stall_x7", 0, 32'h55); push("stall_x5", 0, 32'h11);
    #1 chk_rd(0); chk_rd(1);

`ifdef REGFILE_SCAN_EN
    begin
      int          beats;
      int          dones;
      bit          held;
      logic [63:0] held_pl;
      iss(0, 1, 21); iss(1, 2, 22);
      @(negedge clk); idle();
      for (int i = 0; i < 32; i++) begin m_val[i] = '0; m_tag[i] = '0; end
      m_val[5] = 32'h11; m_val[6] = 32'h66; m_val[7] = 32'h55; m_val[9] = 32'hB;
      m_tag[1] = 5'd21;  m_tag[2] = 5'd22;
      for (int i = 0; i < 32; i++)
        sb.push_back('{$sformatf("scan_beat_%0d", i), {22'b0, 5'(i), m_tag[i], m_val[i]}});

      scan_req = 1'b1;
      @(negedge clk); scan_req = 1'b0;
      beats = 0; dones = 0; held = 1'b0; held_pl = '0;
      for (int c = 0; c < 200 && beats < 32; c++) begin
        if (scan_done) dones++;
        if (held) begin
          n_tests++;
          assert ({22'b0, scan_idx, scan_tag, scan_val} === held_pl) else begin
            n_fail++;
            $error("FAIL scan_hold: observed %0h expected %0h",
                   {22'b0, scan_idx, scan_tag, scan_val}, held_pl);
          end
        end
        scan_ready = c[0];
        held = 1'b0;
        if (scan_valid && scan_ready) begin
          chk({22'b0, scan_idx, scan_tag, scan_val});
          beats++;
        end else if (scan_valid) begin
          held    = 1'b1;
          held_pl = {22'b0, scan_idx, scan_tag, scan_val};
        end
        @(negedge clk);
      end
      scan_ready = 1'b0;
      n_tests++;
      assert (beats == 32) else begin
        n_fail++;
        $error("FAIL scan_beats: observed %0d expected 32", beats);
      end
      n_tests++;
      assert (dones == 0) else begin
        n_fail++;
        $error("FAIL scan_early_done: observed %0d expected 0", dones);
      end
      push("scan_done_pulse", 0, 1);  chk({63'b0, scan_done});
      push("scan_idle_valid", 0, 0);  chk({63'b0, scan_valid});
      @(negedge clk);
      push("scan_done_clear", 0, 0);  chk({63'b0, scan_done});

      // Asynchronous reset in the middle of a scan
      scan_req = 1'b1;
      @(negedge clk); scan_req = 1'b0;
      @(negedge clk);
      push("scan_mid_valid", 0, 1); chk({63'b0, scan_valid});
      #2 rst = 1'b1;
      #1 push("scan_rst_valid", 0, 0); chk({63'b0, scan_valid});
      @(negedge clk); rst = 1'b0;
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
